// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer: buffers keypad/host commands in a FIFO and issues them
// one at a time to the calc datapath using its 2-bit status handshake,
// captures the serialized display digits, and detects calc error or hang.
//
// Ports:
//   clock, reset        system clock (rising edge), async active-low reset
//   cmd_in/cmd_valid    command push; accepted when cmd_valid && cmd_ready
//   cmd_ready           FIFO not full
//   clr_err             one-cycle pulse, leaves ERROR via flush + RECOVER
//   calc_cmd            registered command to calc (IDLE_CMD when idle)
//   calc_reset          active-high reset to calc, pulsed during RECOVER
//   calc_status         from calc: 00 error, 01 busy, 10 ready
//   calc_data/calc_pos  streamed display digit and its index
//   disp_digits         captured digits, nibble i = digit i
//   disp_valid          one-cycle pulse when a command completes
//   busy                state != IDLE or FIFO non-empty
//   err/err_code        error flag; 01 calc error, 10 timeout
//   fifo_count          FIFO occupancy
//
// Optional build macro CALC_CMD_SEQUENCER_AUTORECOVER_EN: when defined, ERROR
// recovers by itself after four cycles (clr_err is still honoured).
module calc_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [3:0]  IDLE_CMD    = 4'hD,
  parameter int unsigned RST_PULSE   = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [3:0]                  cmd_in,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        clr_err,
  output logic [3:0]                  calc_cmd,
  output logic                        calc_reset,
  input  logic [1:0]                  calc_status,
  input  logic [3:0]                  calc_data,
  input  logic [3:0]                  calc_pos,
  output logic [31:0]                 disp_digits,
  output logic                        disp_valid,
  output logic                        busy,
  output logic                        err,
  output logic [1:0]                  err_code,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RW = $clog2(RST_PULSE + 1);

  localparam logic [1:0] ST_ERR  = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_RDY  = 2'b10;

  localparam logic [1:0] EC_NONE = 2'b00;
  localparam logic [1:0] EC_CALC = 2'b01;
  localparam logic [1:0] EC_TMO  = 2'b10;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, ERROR, RECOVER} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [3:0]      head;
  logic            push;
  logic            pop;
  logic            flush;
  logic [CW-1:0]   count_nxt;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_hit;
  logic [RW-1:0]   rst_cnt;
  logic            issued;
  logic [1:0]      err_set;
  logic            clr_go;

  assign head      = mem[rd_ptr];
  assign push      = cmd_valid && cmd_ready && !flush;
  assign count_nxt = flush ? '0 : (fifo_count + CW'(push) - CW'(pop));
  // Fires on the last counted cycle so ERROR is entered after TIMEOUT_CYC cycles.
  assign tmo_hit   = (tmo_cnt >= TW'(TIMEOUT_CYC - 1));

`ifdef CALC_CMD_SEQUENCER_AUTORECOVER_EN
  // Cycles spent in ERROR; the fourth cycle triggers the automatic clear.
  logic [1:0] err_age;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_age <= '0;
    end else if (state == ERROR) begin
      err_age <= err_age + 2'd1;
    end else begin
      err_age <= '0;
    end
  end

  assign clr_go = clr_err || ((state == ERROR) && (err_age == 2'd3));
`else
  assign clr_go = clr_err;
`endif

  // Next-state decision; calc error takes priority over timeout.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    flush     = 1'b0;
    err_set   = EC_NONE;
    case (state)
      IDLE: begin
        // A 00 before anything was ever issued is calc still coming out of reset.
        if ((calc_status == ST_ERR) && ((fifo_count != '0) || issued)) begin
          state_nxt = ERROR;
          err_set   = EC_CALC;
        end else if ((calc_status == ST_RDY) && (fifo_count != '0)) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE, WAIT_DONE: begin
        if (calc_status == ST_ERR) begin
          state_nxt = ERROR;
          err_set   = EC_CALC;
        end else if (tmo_hit) begin
          state_nxt = ERROR;
          err_set   = EC_TMO;
        end else if ((state == ISSUE) && (calc_status == ST_BUSY)) begin
          state_nxt = WAIT_DONE;
          pop       = 1'b1;
        end else if ((state == WAIT_DONE) && (calc_status == ST_RDY)) begin
          state_nxt = IDLE;
        end
      end
      ERROR: begin
        if (clr_go) begin
          state_nxt = RECOVER;
          flush     = 1'b1;
        end
      end
      RECOVER: begin
        if (rst_cnt == RW'(RST_PULSE - 1)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage needs no reset; occupancy lives in the pointers and count.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= cmd_in;
    end
  end

  // State register, FIFO bookkeeping and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      cmd_ready   <= 1'b1;
      calc_cmd    <= IDLE_CMD;
      calc_reset  <= 1'b0;
      disp_digits <= '0;
      disp_valid  <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      err_code    <= EC_NONE;
      tmo_cnt     <= '0;
      rst_cnt     <= '0;
      issued      <= 1'b0;
    end else begin
      state      <= state_nxt;
      fifo_count <= count_nxt;
      cmd_ready  <= (count_nxt != CW'(FIFO_DEPTH));
      busy       <= (state_nxt != IDLE) || (count_nxt != '0);

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end

      // Head is stable while in ISSUE: only a pop can move rd_ptr.
      calc_cmd   <= (state_nxt == ISSUE) ? head : IDLE_CMD;
      calc_reset <= (state_nxt == RECOVER);
      err        <= (state_nxt == ERROR) || (state_nxt == RECOVER);
      disp_valid <= (state == WAIT_DONE) && (state_nxt == IDLE);

      if ((state == IDLE) && (state_nxt == ISSUE)) begin
        issued <= 1'b1;
      end

      if ((state == ISSUE) || (state == WAIT_DONE)) begin
        if (tmo_cnt != TW'(TIMEOUT_CYC)) tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
        tmo_cnt <= '0;
      end

      rst_cnt <= (state == RECOVER) ? (rst_cnt + RW'(1)) : '0;

      if (err_set != EC_NONE) begin
        err_code <= err_set;
      end else if ((state == RECOVER) && (state_nxt == IDLE)) begin
        err_code <= EC_NONE;
      end

      if ((state == RECOVER) && (state_nxt == IDLE)) begin
        disp_digits <= '0;
      end else if ((state == WAIT_DONE) && !calc_pos[3]) begin
        disp_digits[{calc_pos[2:0], 2'b00} +: 4] <= calc_data;
      end
    end
  end

endmodule

// File: doc/calc_cmd_sequencer.md
Name: calc_cmd_sequencer

Overview:
- Controller that sequences the calculator datapath (calc).
- Buffers keypad/host commands in a FIFO and issues them one at a time, using the calculator's 2-bit status handshake.
- Captures the eight serialized display digits into a parallel register and detects datapath error or hang.
- Sits between the keypad front-end and calc; owns calc's active-high reset.

Parameters:
- FIFO_DEPTH, 8, command FIFO entries; power of two, 2..16.
- TIMEOUT_CYC, 1024, max cycles waiting in ISSUE or WAIT_DONE before a timeout error.
- IDLE_CMD, 4'hD, value driven on calc_cmd when no command is being issued.
- RST_PULSE, 2, cycles calc_reset is held high on an error-recovery reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; single clock domain.
- cmd_in  in  4  command code: 0-9 digit, A add, B sub, C mul, E equals, F backspace.
- cmd_valid  in  1  cmd_in valid; accepted when cmd_valid && cmd_ready.
- cmd_ready  out  1  FIFO not full.
- clr_err  in  1  one-cycle pulse that clears ERROR.
- calc_cmd  out  4  command to calc; registered.
- calc_reset  out  1  active-high reset to calc.
- calc_status  in  2  from calc: 00 error, 01 busy, 10 ready.
- calc_data  in  4  from calc: display digit.
- calc_pos  in  4  from calc: digit index.
- disp_digits  out  32  captured digits; nibble i = digit i.
- disp_valid  out  1  one-cycle pulse when disp_digits is updated.
- busy  out  1  high when state != IDLE or FIFO non-empty.
- err  out  1  high in ERROR state.
- err_code  out  2  01 = calc error, 10 = timeout, 00 = none.
- fifo_count  out  log2(FIFO_DEPTH)+1  occupancy.

Behaviour:
- Reset values (reset low):
  - FIFO empty, fifo_count=0, cmd_ready=1.
  - calc_cmd=IDLE_CMD, calc_reset=0.
  - disp_digits=0, disp_valid=0, busy=0, err=0, err_code=00, state=IDLE.
- FIFO: synchronous, first-word fall-through head.
  - Push when cmd_valid && cmd_ready.
  - Push and pop in the same cycle: count unchanged, both take effect.
  - Push while full: ignored (cmd_ready=0).
  - Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, ISSUE, WAIT_DONE, ERROR, RECOVER.
- IDLE:
  - Enter ISSUE when FIFO non-empty && calc_status==10.
  - In the same edge, load calc_cmd <= head and clear the timeout counter.
  - Otherwise calc_cmd=IDLE_CMD.
- ISSUE:
  - Hold calc_cmd = head.
  - On calc_status==01: pop FIFO, calc_cmd <= IDLE_CMD, go to WAIT_DONE.
  - The command is popped exactly once.
- WAIT_DONE:
  - Each cycle with calc_pos<8, write disp_digits[4*calc_pos+:4] <= calc_data.
  - On calc_status==10: pulse disp_valid for 1 cycle, return to IDLE.
  - Earliest issue of the next command is the cycle after the return to IDLE.
- Error detection:
  - calc_status==00 in ISSUE or WAIT_DONE: go to ERROR, err_code=01.
  - calc_status==00 in IDLE: same, unless the FIFO is empty and no command has been issued since reset.
- Timeout:
  - Counter increments each cycle in ISSUE/WAIT_DONE.
  - When it reaches TIMEOUT_CYC: go to ERROR, err_code=10.
  - The counter saturates and never wraps.
- ERROR:
  - err=1; calc_cmd=IDLE_CMD.
  - FIFO keeps accepting until full; no commands are issued.
  - clr_err: flush FIFO, go to RECOVER.
  - clr_err in any other state is ignored.
- RECOVER:
  - calc_reset=1 for RST_PULSE cycles.
  - Then clear err, err_code and disp_digits, and return to IDLE.
- Simultaneous events:
  - An error and a timeout in the same cycle: err_code=01 wins.
  - A push during flush is dropped.
- Reset asserted mid-operation: immediate return to the reset values; calc_reset is not driven (calc shares the system reset at top level).

Optional Feature:
- Macro: CALC_CMD_SEQUENCER_AUTORECOVER_EN.
- Defined: ERROR behaves as if clr_err were pulsed 4 cycles after entry, i.e. automatic flush, RECOVER, then IDLE. err remains 1 through those 4 cycles, so software can observe it. clr_err is still honoured.
- Undefined: ERROR is sticky until clr_err or reset.

Test Plan:
- Push 1,2,A,3,E with the calc model returning 01 for 3 cycles then 10, and pos/data streaming digits of 15 → five issues in order, each popped once; disp_digits=32'h00000015; disp_valid pulses once per command.
- Push FIFO_DEPTH+2 commands while calc_status stays 01 → cmd_ready drops at count=8; extra pushes dropped; fifo_count=8.
- Issue a command, then hold calc_status=01 → at cycle TIMEOUT_CYC: err=1, err_code=10; later clr_err → calc_reset high 2 cycles, then IDLE with err=0.
- calc_status=00 during WAIT_DONE → ERROR with err_code=01; new pushes are accepted but nothing is issued.
- Push and pop in the same cycle with count=3 → count stays 3; entry ordering preserved.
- Drive reset low mid-ISSUE → all outputs at reset values the same cycle; FIFO empty after release.
